// File: rtl/ir_nec_pkg.sv
// rtl/ir_nec_pkg.sv - NEC frame state encoding and per-state unit counts
package ir_nec_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    RPT_MARK,
    RPT_SPACE,
    GAP
  } necState_t;

  localparam int LEAD_MARK_U  = 16;
  localparam int LEAD_SPACE_U = 8;
  localparam int RPT_SPACE_U  = 4;
  localparam int BIT0_SPACE_U = 1;
  localparam int BIT1_SPACE_U = 3;
  localparam int STOP_U       = 1;
  localparam int BIT_MARK_U   = 1;

  function automatic logic isMark(necState_t s);
    return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK) || (s == RPT_MARK);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// rtl/ir_carrier_gen.sv - carrier square wave, restartable at the start of each burst
module ir_carrier_gen #(
  parameter int CARRIER_HALF = 658
) (
  input  logic master_clk,
  input  logic resetn,
  input  logic restart,
  input  logic enable,
  output logic carrier
);

  localparam int PW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(CARRIER_HALF - 1);

  logic [PW-1:0] phase;

  // Held low while disabled, so the registered carrier is already gated by the envelope.
  always_ff @(posedge master_clk or negedge resetn) begin
    if (!resetn) begin
      phase   <= '0;
      carrier <= 1'b0;
    end else if (restart) begin
      phase   <= '0;
      carrier <= 1'b1;
    end else if (enable) begin
      if (phase == PHASE_LAST) begin
        phase   <= '0;
        carrier <= ~carrier;
      end else begin
        phase <= phase + 1'b1;
      end
    end else begin
      phase   <= '0;
      carrier <= 1'b0;
    end
  end

endmodule

// File: rtl/ir_nec_transmit.sv
// rtl/ir_nec_transmit.sv - NEC IR frame transmitter with 38 kHz carrier output
module ir_nec_transmit #(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_HALF = 658,
  parameter int GAP_UNITS    = 72
) (
  input  logic        master_clk,
  input  logic        resetn,
  input  logic [31:0] iDATA,
  input  logic        iSEND,
  input  logic        iREPEAT,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oENV,
  output logic        oIRDA
);

  import ir_nec_pkg::*;

  localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CW-1:0] CYCLE_LAST = CW'(UNIT_CYCLES - 1);
  localparam int MAXU = (GAP_UNITS > LEAD_MARK_U) ? GAP_UNITS : LEAD_MARK_U;
  localparam int UW = $clog2(MAXU + 1);

  necState_t     state, stateNext;
  logic [CW-1:0] cycleCnt, cycleNext;
  logic [UW-1:0] unitCnt, unitNext, unitLast;
  logic [31:0]   shiftReg, shiftNext;
  logic [4:0]    bitCnt, bitNext;
  logic          unitTick, stateEnd;
  logic          envNext, busyNext, doneNext, carrierRestart;

  always_ff @(posedge master_clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cycleCnt <= '0;
      unitCnt  <= '0;
      shiftReg <= '0;
      bitCnt   <= '0;
      oBUSY    <= 1'b0;
      oDONE    <= 1'b0;
      oENV     <= 1'b0;
    end else begin
      state    <= stateNext;
      cycleCnt <= cycleNext;
      unitCnt  <= unitNext;
      shiftReg <= shiftNext;
      bitCnt   <= bitNext;
      oBUSY    <= busyNext;
      oDONE    <= doneNext;
      oENV     <= envNext;
    end
  end

  always_comb begin
    unitLast = '0;
    case (state)
      LEAD_MARK:  unitLast = UW'(LEAD_MARK_U - 1);
      LEAD_SPACE: unitLast = UW'(LEAD_SPACE_U - 1);
      BIT_MARK:   unitLast = UW'(BIT_MARK_U - 1);
      BIT_SPACE:  unitLast = shiftReg[0] ? UW'(BIT1_SPACE_U - 1) : UW'(BIT0_SPACE_U - 1);
      STOP_MARK:  unitLast = UW'(STOP_U - 1);
      RPT_MARK:   unitLast = UW'(LEAD_MARK_U - 1);
      RPT_SPACE:  unitLast = UW'(RPT_SPACE_U - 1);
      GAP:        unitLast = UW'(GAP_UNITS - 1);
      default:    unitLast = '0;
    endcase
  end

  assign unitTick = (cycleCnt == CYCLE_LAST);
  assign stateEnd = unitTick && (unitCnt == unitLast);

  always_comb begin
    stateNext = state;
    shiftNext = shiftReg;
    bitNext   = bitCnt;
    case (state)
      IDLE: begin
        if (iSEND) begin
          stateNext = LEAD_MARK;
          shiftNext = iDATA;
          bitNext   = '0;
        end else if (iREPEAT) begin
          stateNext = RPT_MARK;
        end
      end
      LEAD_MARK:  if (stateEnd) stateNext = LEAD_SPACE;
      LEAD_SPACE: if (stateEnd) stateNext = BIT_MARK;
      BIT_MARK:   if (stateEnd) stateNext = BIT_SPACE;
      BIT_SPACE: begin
        if (stateEnd) begin
          shiftNext = shiftReg >> 1;
          // Bit count stops at 31 instead of wrapping back into the frame.
          if (bitCnt == 5'd31) begin
            stateNext = STOP_MARK;
          end else begin
            bitNext   = bitCnt + 1'b1;
            stateNext = BIT_MARK;
          end
        end
      end
      STOP_MARK:  if (stateEnd) stateNext = GAP;
      RPT_MARK:   if (stateEnd) stateNext = RPT_SPACE;
      RPT_SPACE:  if (stateEnd) stateNext = STOP_MARK;
      GAP:        if (stateEnd) stateNext = IDLE;
      default:    stateNext = IDLE;
    endcase

    if ((stateNext != state) || (state == IDLE)) begin
      cycleNext = '0;
      unitNext  = '0;
    end else if (unitTick) begin
      cycleNext = '0;
      unitNext  = unitCnt + 1'b1;
    end else begin
      cycleNext = cycleCnt + 1'b1;
      unitNext  = unitCnt;
    end
  end

  // Outputs are registered from the next-state view so they line up with the state they describe.
  always_comb begin
    envNext        = isMark(stateNext);
    busyNext       = (stateNext != IDLE);
    doneNext       = (stateNext == STOP_MARK) && (cycleNext == CYCLE_LAST) &&
                     (unitNext == UW'(STOP_U - 1));
    carrierRestart = envNext && (stateNext != state);
  end

  ir_carrier_gen #(
    .CARRIER_HALF(CARRIER_HALF)
  ) u_carrier (
    .master_clk(master_clk),
    .resetn    (resetn),
    .restart   (carrierRestart),
    .enable    (envNext),
    .carrier   (oIRDA)
  );

endmodule

// File: tb/tb_ir_nec_transmit.sv
// tb/tb_ir_nec_transmit.sv - self-checking bench for the NEC IR transmitter
`timescale 1ns/1ps
module tb_ir_nec_transmit;

  localparam int U     = 4;
  localparam int HALF  = 1;
  localparam int GAPU  = 2;
  localparam int U2    = 200;
  localparam int HALF2 = 658;

  logic master_clk = 1'b0;
  always #5 master_clk = ~master_clk;

  logic        resetn, iSEND, iREPEAT;
  logic [31:0] iDATA;
  logic        oBUSY, oDONE, oENV, oIRDA;
  logic        resetn2, iSEND2, iREPEAT2;
  logic [31:0] iDATA2;
  logic        oBUSY2, oDONE2, oENV2, oIRDA2;

  ir_nec_transmit #(.UNIT_CYCLES(U), .CARRIER_HALF(HALF), .GAP_UNITS(GAPU)) dut (
    .master_clk(master_clk), .resetn(resetn), .iDATA(iDATA), .iSEND(iSEND),
    .iREPEAT(iREPEAT), .oBUSY(oBUSY), .oDONE(oDONE), .oENV(oENV), .oIRDA(oIRDA));

  ir_nec_transmit #(.UNIT_CYCLES(U2), .CARRIER_HALF(HALF2), .GAP_UNITS(GAPU)) dut2 (
    .master_clk(master_clk), .resetn(resetn2), .iDATA(iDATA2), .iSEND(iSEND2),
    .iREPEAT(iREPEAT2), .oBUSY(oBUSY2), .oDONE(oDONE2), .oENV(oENV2), .oIRDA(oIRDA2));

  typedef struct {
    string       name;
    bit          send;
    bit          rpt;
    logic [31:0] data;
    int          units;
  } vec_t;

  vec_t vecs[6];
  int   checks = 0;
  int   failures = 0;
  bit   expEnv[$];
  bit   expIrda[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic addSeg(input bit mark, input int units);
    for (int k = 0; k < units * U; k++) begin
      expEnv.push_back(mark);
      expIrda.push_back(mark && (((k / HALF) % 2) == 0));
    end
  endtask

  task automatic buildFrame(input bit rpt, input logic [31:0] d);
    expEnv.delete();
    expIrda.delete();
    if (rpt) begin
      addSeg(1, 16); addSeg(0, 4); addSeg(1, 1);
    end else begin
      addSeg(1, 16); addSeg(0, 8);
      for (int i = 0; i < 32; i++) begin
        addSeg(1, 1);
        addSeg(0, d[i] ? 3 : 1);
      end
      addSeg(1, 1);
    end
  endtask

  task automatic runFrame(input string name, input bit s, input bit r,
                          input logic [31:0] d, input int units);
    int total, envBad, irdaBad, busyBad, doneCnt, doneAt, idleBad;
    envBad = 0; irdaBad = 0; busyBad = 0; doneCnt = 0; doneAt = -1; idleBad = 0;
    buildFrame(r && !s, d);
    addSeg(0, GAPU);
    total = expEnv.size();
    @(negedge master_clk);
    iSEND = s; iREPEAT = r; iDATA = d;
    @(negedge master_clk);
    iSEND = 0; iREPEAT = 0; iDATA = $urandom;
    for (int i = 0; i < total; i++) begin
      if (oENV !== expEnv[i]) envBad++;
      if (oIRDA !== expIrda[i]) irdaBad++;
      if (oBUSY !== 1'b1) busyBad++;
      if (oDONE === 1'b1) begin doneCnt++; doneAt = i; end
      iSEND = (i == 10);
      iDATA = $urandom;
      @(negedge master_clk);
    end
    for (int i = 0; i < 6; i++) begin
      if ({oBUSY, oENV, oIRDA, oDONE} !== 4'b0) idleBad++;
      @(negedge master_clk);
    end
    check({name, "_env"}, envBad, 0);
    check({name, "_irda"}, irdaBad, 0);
    check({name, "_busy"}, busyBad, 0);
    check({name, "_done_count"}, doneCnt, 1);
    check({name, "_done_at"}, doneAt, units * U - 1);
    check({name, "_idle_after"}, idleBad, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad, idx, highs, rise, envBad2;
    bit prev, expC;
    logic [31:0] d;

    vecs[0] = '{"frame_f708fb04", 1, 0, 32'hF708FB04, 121};
    vecs[1] = '{"frame_zeros",    1, 0, 32'h00000000, 89};
    vecs[2] = '{"frame_ones",     1, 0, 32'hFFFFFFFF, 153};
    vecs[3] = '{"repeat",         0, 1, 32'h12345678, 21};
    vecs[4] = '{"send_and_rpt",   1, 1, 32'h00000001, 91};
    vecs[5] = '{"frame_bit31",    1, 0, 32'h80000000, 91};

    resetn = 0; iSEND = 0; iREPEAT = 0; iDATA = '0;
    resetn2 = 0; iSEND2 = 0; iREPEAT2 = 0; iDATA2 = '0;
    repeat (3) @(negedge master_clk);
    check("reset_state", {oBUSY, oDONE, oENV, oIRDA}, 0);
    resetn = 1; resetn2 = 1;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if ({oBUSY, oDONE, oENV, oIRDA} !== 4'b0) bad++;
      @(negedge master_clk);
    end
    check("reset_idle", bad, 0);

    foreach (vecs[v]) runFrame(vecs[v].name, vecs[v].send, vecs[v].rpt, vecs[v].data, vecs[v].units);

    for (int n = 0; n < 4; n++) begin
      d = $urandom;
      runFrame("rand", 1, 1'($urandom_range(0, 1)), d, 89 + 2 * $countones(d));
    end

    d = 32'hF708FB04;
    idx = 24 * U + U + 1;
    for (int i = 0; i < 10; i++) idx += (1 + (d[i] ? 3 : 1)) * U;
    @(negedge master_clk);
    iSEND = 1; iDATA = d;
    @(negedge master_clk);
    iSEND = 0;
    for (int i = 0; i < idx; i++) @(negedge master_clk);
    check("pre_reset_busy", oBUSY, 1);
    #1 resetn = 0;
    #1 check("reset_async", {oBUSY, oDONE, oENV, oIRDA}, 0);
    repeat (3) @(negedge master_clk);
    resetn = 1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if ({oBUSY, oDONE, oENV, oIRDA} !== 4'b0) bad++;
      @(negedge master_clk);
    end
    check("post_reset_idle", bad, 0);
    runFrame("after_reset", 1, 0, 32'hF708FB04, 121);

    bad = 0; highs = 0; rise = -1; prev = 0; envBad2 = 0;
    @(negedge master_clk);
    iSEND2 = 1; iDATA2 = $urandom;
    @(negedge master_clk);
    iSEND2 = 0;
    for (int k = 0; k < 16 * U2; k++) begin
      expC = ((k / HALF2) % 2) == 0;
      if (oIRDA2 !== expC) bad++;
      if (oENV2 !== 1'b1) envBad2++;
      if (k < HALF2 && oIRDA2 === 1'b1) highs++;
      if (k > 0 && oIRDA2 === 1'b1 && !prev && rise < 0) rise = k;
      prev = oIRDA2;
      @(negedge master_clk);
    end
    check("carrier_wave", bad, 0);
    check("carrier_env", envBad2, 0);
    check("carrier_first_half", highs, HALF2);
    check("carrier_period", rise, 2 * HALF2);
    #1 resetn2 = 0;
    #1 check("carrier_reset", {oBUSY2, oDONE2, oENV2, oIRDA2}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
